// File: rtl/regfile_write_arbiter.sv
// regfile_write_arbiter
//
// Round-robin arbiter sharing the single write port of a 4-entry register file
// between three requesters: ALU writeback (0), load return (1) and host/debug (2).
// At most one request is granted per cycle. The winner's address/data are
// captured into a one-deep output stage that drives the register file's write
// decoder directly, so a grant in cycle t appears as a write strobe in t+1.
//
// Ports
//   clk_i          clock, all state updates on the rising edge
//   rst_i          synchronous active-high reset
//   stall_i        suppresses granting this cycle (write strobe drops next cycle)
//   req_i[2:0]     pending write per requester, held until granted
//   addrN_i        destination register of requester N
//   dataN_i        write data of requester N
//   gnt_o[2:0]     combinational one-hot (or zero) grant
//   wr_o           registered write address to the register file decoder
//   write_enable_o registered write strobe
//   wdata_o        registered write data
//   busy_ptr_o     current round-robin priority pointer (debug)

module regfile_write_arbiter #(
  parameter int unsigned Width = 8
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             stall_i,
  input  logic [2:0]       req_i,
  input  logic [1:0]       addr0_i,
  input  logic [1:0]       addr1_i,
  input  logic [1:0]       addr2_i,
  input  logic [Width-1:0] data0_i,
  input  logic [Width-1:0] data1_i,
  input  logic [Width-1:0] data2_i,
  output logic [2:0]       gnt_o,
  output logic [1:0]       wr_o,
  output logic             write_enable_o,
  output logic [Width-1:0] wdata_o,
  output logic [1:0]       busy_ptr_o
);

  logic [1:0]       ptr_q, ptr_d;
  logic             we_q, we_d;
  logic [1:0]       wr_q, wr_d;
  logic [Width-1:0] wdata_q, wdata_d;

  logic [1:0]       ptr_eff;
  logic [2:0]       gnt;
  logic [1:0]       ptr_nxt;
  logic [1:0]       sel_addr;
  logic [Width-1:0] sel_data;

  // The pointer only ever holds 0..2; an illegal 3 is folded back to 0 so the
  // arbiter always recovers to a defined priority order.
  assign ptr_eff = (ptr_q == 2'd3) ? 2'd0 : ptr_q;

  // Priority search starting at the pointer and wrapping modulo 3.
  always_comb begin
    gnt = 3'b000;
    case (ptr_eff)
      2'd0: begin
        if      (req_i[0]) gnt = 3'b001;
        else if (req_i[1]) gnt = 3'b010;
        else if (req_i[2]) gnt = 3'b100;
      end
      2'd1: begin
        if      (req_i[1]) gnt = 3'b010;
        else if (req_i[2]) gnt = 3'b100;
        else if (req_i[0]) gnt = 3'b001;
      end
      2'd2: begin
        if      (req_i[2]) gnt = 3'b100;
        else if (req_i[0]) gnt = 3'b001;
        else if (req_i[1]) gnt = 3'b010;
      end
      default: gnt = 3'b000;
    endcase
    // Reset and stall veto the grant in the same cycle.
    if (rst_i || stall_i) begin
      gnt = 3'b000;
    end
  end

  // Winner's payload and the pointer position just past the winner.
  always_comb begin
    sel_addr = addr0_i;
    sel_data = data0_i;
    ptr_nxt  = ptr_eff;
    unique case (1'b1)
      gnt[0]: begin
        sel_addr = addr0_i;
        sel_data = data0_i;
        ptr_nxt  = 2'd1;
      end
      gnt[1]: begin
        sel_addr = addr1_i;
        sel_data = data1_i;
        ptr_nxt  = 2'd2;
      end
      gnt[2]: begin
        sel_addr = addr2_i;
        sel_data = data2_i;
        ptr_nxt  = 2'd0;
      end
      default: begin
        sel_addr = addr0_i;
        sel_data = data0_i;
        ptr_nxt  = ptr_eff;
      end
    endcase
  end

  // Output stage: load on a grant, otherwise drop the strobe and hold
  // address/data so the decoder inputs stay quiet.
  always_comb begin
    ptr_d   = ptr_eff;
    we_d    = 1'b0;
    wr_d    = wr_q;
    wdata_d = wdata_q;
    if (|gnt) begin
      ptr_d   = ptr_nxt;
      we_d    = 1'b1;
      wr_d    = sel_addr;
      wdata_d = sel_data;
    end
  end

  // A reset also discards any write sitting in the output stage; the granted
  // requester has already retired its request and will not retry.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      ptr_q   <= 2'd0;
      we_q    <= 1'b0;
      wr_q    <= 2'd0;
      wdata_q <= '0;
    end else begin
      ptr_q   <= ptr_d;
      we_q    <= we_d;
      wr_q    <= wr_d;
      wdata_q <= wdata_d;
    end
  end

  assign gnt_o          = gnt;
  assign wr_o           = wr_q;
  assign write_enable_o = we_q;
  assign wdata_o        = wdata_q;
  assign busy_ptr_o     = ptr_eff;

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Self-checking bench for regfile_write_arbiter: directed scenarios plus a
// randomized run, all compared against a round-robin reference model.

module tb_regfile_write_arbiter;

  logic       clk = 1'b0;
  logic       rst;
  logic       stall;
  logic [2:0] req;
  logic [1:0] addr [3];
  logic [7:0] data [3];
  logic [2:0] gnt;
  logic [1:0] wr;
  logic       write_enable;
  logic [7:0] wdata;
  logic [1:0] busy_ptr;

  int vectors     = 0;
  int miscompares = 0;

  // Reference model state.
  int         m_ptr;
  logic       m_we;
  logic [1:0] m_wr;
  logic [7:0] m_wdata;

  // Register file image fed by the DUT's write port.
  logic [7:0] rf [4];

  regfile_write_arbiter #(.Width(8)) dut (
    .clk_i          (clk),
    .rst_i          (rst),
    .stall_i        (stall),
    .req_i          (req),
    .addr0_i        (addr[0]),
    .addr1_i        (addr[1]),
    .addr2_i        (addr[2]),
    .data0_i        (data[0]),
    .data1_i        (data[1]),
    .data2_i        (data[2]),
    .gnt_o          (gnt),
    .wr_o           (wr),
    .write_enable_o (write_enable),
    .wdata_o        (wdata),
    .busy_ptr_o     (busy_ptr)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (write_enable === 1'b1) rf[wr] <= wdata;
  end

  // First requester at or after the pointer, wrapping modulo 3.
  function automatic logic [2:0] model_gnt();
    if (rst || stall) return 3'b000;
    for (int k = 0; k < 3; k++) begin
      int idx;
      idx = (m_ptr + k) % 3;
      if (req[idx]) return 3'(1 << idx);
    end
    return 3'b000;
  endfunction

  task automatic model_edge(input logic [2:0] g);
    if (rst) begin
      m_ptr = 0; m_we = 1'b0; m_wr = 2'd0; m_wdata = 8'h00;
    end else if (g != 3'b000) begin
      for (int i = 0; i < 3; i++) begin
        if (g[i]) begin
          m_we = 1'b1; m_wr = addr[i]; m_wdata = data[i]; m_ptr = (i + 1) % 3;
        end
      end
    end else begin
      m_we = 1'b0;
    end
  endtask

  // One clock: model sees the same inputs the DUT samples at the edge.
  task automatic advance();
    logic [2:0] g;
    g = model_gnt();
    @(posedge clk);
    model_edge(g);
    #1;
  endtask

  task automatic do_reset_cycle();
    rst = 1'b1; req = 3'b000; stall = 1'b0;
    advance();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; stall = 1'b0; req = 3'b111;
    for (int i = 0; i < 3; i++) begin addr[i] = 2'(i); data[i] = 8'hF0 + 8'(i); end
    for (int c = 0; c < 2; c++) begin
      #1;
      vectors++;
      if (gnt !== 3'b000) begin
        miscompares++; $display("FAIL reset_gnt cycle %0d got %b exp 000", c, gnt);
      end
      advance();
    end
    rst = 1'b0; req = 3'b000;
    vectors++;
    if ({write_enable, wr, wdata, busy_ptr} !== {1'b0, 2'd0, 8'h00, 2'd0}) begin
      miscompares++;
      $display("FAIL reset_out got we=%b wr=%0d wdata=%h ptr=%0d exp 0/0/00/0",
               write_enable, wr, wdata, busy_ptr);
    end
  endtask

  task automatic test_single();
    req = 3'b010; addr[1] = 2'd2; data[1] = 8'hA5;
    #1;
    vectors++;
    if (gnt !== 3'b010) begin
      miscompares++; $display("FAIL single_gnt got %b exp 010", gnt);
    end
    advance();
    req = 3'b000;
    vectors++;
    if ({write_enable, wr, wdata, busy_ptr} !== {1'b1, 2'd2, 8'hA5, 2'd2}) begin
      miscompares++;
      $display("FAIL single_write got we=%b wr=%0d wdata=%h ptr=%0d exp 1/2/a5/2",
               write_enable, wr, wdata, busy_ptr);
    end
    advance();
    vectors++;
    if (write_enable !== 1'b0) begin
      miscompares++; $display("FAIL single_idle got we=%b exp 0", write_enable);
    end
  endtask

  task automatic test_contention();
    logic [2:0] exp_seq [6];
    exp_seq = '{3'b001, 3'b010, 3'b100, 3'b001, 3'b010, 3'b100};
    do_reset_cycle();
    req = 3'b111;
    addr[0] = 2'd0; addr[1] = 2'd1; addr[2] = 2'd2;
    data[0] = 8'h11; data[1] = 8'h22; data[2] = 8'h33;
    for (int c = 0; c < 6; c++) begin
      #1;
      vectors++;
      if (gnt !== exp_seq[c]) begin
        miscompares++; $display("FAIL contention_gnt cycle %0d got %b exp %b", c, gnt, exp_seq[c]);
      end
      advance();
      vectors++;
      if ({write_enable, wr, wdata} !== {1'b1, 2'(c % 3), 8'(8'h11 * (c % 3 + 1))}) begin
        miscompares++;
        $display("FAIL contention_write cycle %0d got we=%b wr=%0d wdata=%h exp wr=%0d",
                 c, write_enable, wr, wdata, c % 3);
      end
    end
    req = 3'b000;
    advance();
  endtask

  task automatic test_stall();
    logic [2:0] exp_after [2];
    exp_after = '{3'b001, 3'b100};
    do_reset_cycle();
    req = 3'b101; stall = 1'b1;
    addr[0] = 2'd1; data[0] = 8'h5A; addr[2] = 2'd3; data[2] = 8'hC3;
    for (int c = 0; c < 3; c++) begin
      #1;
      vectors++;
      if (gnt !== 3'b000) begin
        miscompares++; $display("FAIL stall_gnt cycle %0d got %b exp 000", c, gnt);
      end
      advance();
      vectors++;
      if (write_enable !== 1'b0) begin
        miscompares++; $display("FAIL stall_we cycle %0d got %b exp 0", c, write_enable);
      end
    end
    stall = 1'b0;
    for (int c = 0; c < 2; c++) begin
      #1;
      vectors++;
      if (gnt !== exp_after[c]) begin
        miscompares++; $display("FAIL stall_release cycle %0d got %b exp %b", c, gnt, exp_after[c]);
      end
      advance();
      vectors++;
      if ({write_enable, wr, wdata} !== {m_we, m_wr, m_wdata}) begin
        miscompares++;
        $display("FAIL stall_write cycle %0d got %b/%0d/%h exp %b/%0d/%h",
                 c, write_enable, wr, wdata, m_we, m_wr, m_wdata);
      end
    end
    req = 3'b000;
    advance();
  endtask

  task automatic test_same_addr();
    do_reset_cycle();
    req = 3'b001; addr[0] = 2'd0; data[0] = 8'h00;
    advance();
    req = 3'b011; addr[0] = 2'd3; addr[1] = 2'd3; data[0] = 8'h01; data[1] = 8'h02;
    #1;
    vectors++;
    if (gnt !== 3'b010 || busy_ptr !== 2'd1) begin
      miscompares++; $display("FAIL same_addr_gnt1 got %b ptr %0d exp 010 ptr 1", gnt, busy_ptr);
    end
    advance();
    req = 3'b001;
    vectors++;
    if ({write_enable, wr, wdata} !== {1'b1, 2'd3, 8'h02}) begin
      miscompares++; $display("FAIL same_addr_w1 got %b/%0d/%h exp 1/3/02", write_enable, wr, wdata);
    end
    #1;
    vectors++;
    if (gnt !== 3'b001) begin
      miscompares++; $display("FAIL same_addr_gnt2 got %b exp 001", gnt);
    end
    advance();
    req = 3'b000;
    vectors++;
    if ({write_enable, wr, wdata} !== {1'b1, 2'd3, 8'h01}) begin
      miscompares++; $display("FAIL same_addr_w2 got %b/%0d/%h exp 1/3/01", write_enable, wr, wdata);
    end
    advance();
    vectors++;
    if (rf[3] !== 8'h01) begin
      miscompares++; $display("FAIL same_addr_final got %h exp 01", rf[3]);
    end
  endtask

  task automatic test_reset_midop();
    do_reset_cycle();
    req = 3'b100; addr[2] = 2'd1; data[2] = 8'h77;
    #1;
    vectors++;
    if (gnt !== 3'b100) begin
      miscompares++; $display("FAIL midrst_gnt got %b exp 100", gnt);
    end
    advance();
    rst = 1'b1; req = 3'b000;
    #1;
    vectors++;
    if (gnt !== 3'b000 || write_enable !== 1'b1) begin
      miscompares++; $display("FAIL midrst_pending got gnt=%b we=%b exp 000/1", gnt, write_enable);
    end
    advance();
    rst = 1'b0;
    vectors++;
    if (write_enable !== 1'b0 || busy_ptr !== 2'd0) begin
      miscompares++; $display("FAIL midrst_drop got we=%b ptr=%0d exp 0/0", write_enable, busy_ptr);
    end
    req = 3'b111;
    #1;
    vectors++;
    if (gnt !== 3'b001) begin
      miscompares++; $display("FAIL midrst_next got %b exp 001", gnt);
    end
    advance();
    req = 3'b000;
    advance();
  endtask

  task automatic test_random();
    logic [2:0] g;
    do_reset_cycle();
    for (int c = 0; c < 300; c++) begin
      for (int i = 0; i < 3; i++) begin
        if (!req[i] && $urandom_range(1, 0) == 1) begin
          req[i] = 1'b1; addr[i] = 2'($urandom); data[i] = 8'($urandom);
        end
      end
      stall = ($urandom_range(4, 0) == 0);
      #1;
      g = model_gnt();
      vectors++;
      if (gnt !== g) begin
        miscompares++; $display("FAIL random_gnt cycle %0d got %b exp %b", c, gnt, g);
      end
      advance();
      vectors++;
      if ({write_enable, busy_ptr} !== {m_we, 2'(m_ptr)} ||
          (m_we && {wr, wdata} !== {m_wr, m_wdata})) begin
        miscompares++;
        $display("FAIL random_out cycle %0d got %b/%0d/%h/%0d exp %b/%0d/%h/%0d", c,
                 write_enable, wr, wdata, busy_ptr, m_we, m_wr, m_wdata, m_ptr);
      end
      // Granted requesters either retire or immediately post a fresh write.
      for (int i = 0; i < 3; i++) begin
        if (g[i]) begin
          if ($urandom_range(1, 0) == 1) req[i] = 1'b0;
          else begin addr[i] = 2'($urandom); data[i] = 8'($urandom); end
        end
      end
    end
    stall = 1'b0; req = 3'b000;
    advance();
  endtask

  initial begin
    for (int i = 0; i < 4; i++) rf[i] = 8'h00;
    m_ptr = 0; m_we = 1'b0; m_wr = 2'd0; m_wdata = 8'h00;
    test_reset();
    test_single();
    test_contention();
    test_stall();
    test_same_addr();
    test_reset_midop();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/regfile_write_arbiter.md
# regfile_write_arbiter

Round-robin arbiter that shares the register file's single write port among three requesters: ALU writeback (port 0), memory load return (port 1) and host/debug write (port 2). Each cycle it grants at most one pending request. It registers the winner's address, data and enable, and drives them straight onto the write-address, write-enable and write-data inputs of the 4-entry register file, whose 2-to-4 write decoder consumes them. Requesters hold their request until granted; the arbiter has no internal buffering beyond the single output stage.

## Interface
- WIDTH, 8, register data width in bits
- clk  input  1  single clock; all state updates on rising edge
- rst  input  1  synchronous, active-high reset
- stall  input  1  when high, no grant is issued and write_enable is 0 in the following cycle
- req  input  3  req[i] = requester i has a pending write
- addr0, addr1, addr2  input  2 each  destination register of requester i
- data0, data1, data2  input  WIDTH each  write data of requester i
- gnt  output  3  one-hot combinational grant; a transfer occurs at an edge where req[i] & gnt[i]
- wr  output  2  registered write address to the register file decoder
- write_enable  output  1  registered write strobe to the register file decoder
- wdata  output  WIDTH  registered write data to the register file
- busy_ptr  output  2  current round-robin priority pointer, for debug

## Operation
- State: priority pointer ptr in {0,1,2}, plus the output register {wr, write_enable, wdata}.
- Grant search order: ptr, (ptr+1) mod 3, (ptr+2) mod 3. The first index with req high wins.
- gnt is one-hot or all-zero. gnt = 0 when stall = 1 or rst = 1 or req = 0.
- On a grant to i: at the next edge, wr <= addr_i, wdata <= data_i, write_enable <= 1, and ptr <= (i+1) mod 3.
- No grant: write_enable <= 0 at the next edge. wr and wdata hold their previous values. ptr is unchanged.
- Requesters keep req/addr/data stable until they see gnt[i] high. They may deassert, or present a new request, from the cycle after the grant.
- A requester that stays high continuously competes again immediately. Rotation guarantees service within 3 grant cycles, so there is no starvation.
- Same-address simultaneous requests: arbitration is unaffected. The loser's write lands later and is therefore the final value.
- ptr is only ever 0, 1 or 2. If value 3 is ever detected, it is treated as 0.
- Reset: gnt = 0 in the reset cycle. At the edge: ptr = 0, write_enable = 0, wr = 2'b00, wdata = 0.
- Reset while a write is in the output stage: that write is dropped (write_enable = 0 after the edge). The granted requester has already seen gnt and does not retry.

## Timing
- Cycle t: req[i] high, gnt[i] high combinationally.
- Edge ending t: output stage loaded.
- Cycle t+1: write_enable = 1 with wr/wdata valid.
- Edge ending t+1: the register file captures the data.
- Grant-to-write latency is 1 cycle. Request-to-register-update is 2 edges.
- Throughput is one write per cycle. Back-to-back grants produce continuous write_enable.
- stall takes effect combinationally in the same cycle on gnt, and on write_enable one cycle later. A write already in the output stage when stall rises still completes.
- Reset values: gnt = 000, wr = 00, write_enable = 0, wdata = 0, busy_ptr = 00.

## Test plan
- Reset check: hold rst for 2 cycles with req = 111. Require gnt = 000 throughout. After release: write_enable = 0, wr = 00, wdata = 0, busy_ptr = 0.
- Single request, stall = 0: req = 010, addr1 = 2, data1 = 8'hA5. Require gnt = 010 in cycle t. In t+1: write_enable = 1, wr = 2, wdata = A5, busy_ptr = 2. In t+2 with req dropped: write_enable = 0.
- Full contention, req = 111 held 6 cycles from ptr = 0, addrs 0/1/2, data 11/22/33. Require gnt sequence 001, 010, 100, 001, 010, 100. Require write stream (wr, wdata) = (0,11), (1,22), (2,33), repeating, each one cycle after its grant.
- Stall: req = 101, stall high for 3 cycles. Require gnt = 000 and write_enable = 0 from the second stall cycle onward. On stall release from ptr = 0: gnt = 001, then 100.
- Same-address conflict: req = 011, both addressing register 3, data0 = 8'h01, data1 = 8'h02, ptr = 1. Require writes in order 02 then 01, so register 3 ends at 8'h01.
- Reset mid-operation: grant port 2 in cycle t, assert rst in t+1. Require write_enable = 0 after the t+1 edge, busy_ptr = 0, and the next grant with req = 111 goes to port 0.
